// File: rtl/matrix_ingest_stream_if.sv
// Handshake, read port and status bundle for matrix_ingest_stream.
// The master drives rows and read requests; the slave (the ingest block) returns status.
interface matrix_ingest_stream_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4
);
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  loaded;
   logic                  err;
   logic [ADDR_WIDTH:0]   word_count;
   logic [DATA_WIDTH-1:0] checksum;

   modport master (
      output start, in_valid, in_data, in_last, rd_en, rd_addr,
      input  in_ready, rd_data, rd_valid, loaded, err, word_count, checksum
   );

   modport slave (
      input  start, in_valid, in_data, in_last, rd_en, rd_addr,
      output in_ready, rd_data, rd_valid, loaded, err, word_count, checksum
   );
endinterface

// File: rtl/matrix_ingest_stream.sv
// Streams DEPTH matrix rows into a local RAM, checks framing against in_last,
// keeps a rotate-XOR checksum and serves registered reads in every state.
module matrix_ingest_stream #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   matrix_ingest_stream_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_e;

   localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
   logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic in_ready, loaded, err, accept, rd_in_range;

   assign accept      = bus.in_valid & in_ready;
   assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_C);

   // NOTE: state updates use <= so every register samples pre-edge values,
   // which is also what gives read-old-data on a same-address read/write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         word_count_q <= '0;
         checksum_q   <= '0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         checksum_q   <= checksum_d;
      end
   end

   // start wins over any beat presented in the same cycle.
   always_comb begin
      // NOTE: defaults first so no path through this block leaves a latch.
      state_d = state_q;
      if (bus.start) begin
         state_d = LOAD;
      end else if (accept) begin
         if (word_count_q == LAST_BEAT) begin
            state_d = bus.in_last ? DONE : ERR;
         end else if (bus.in_last) begin
            state_d = ERR;
         end
      end
   end

   always_comb begin
      in_ready = 1'b0;
      loaded   = 1'b0;
      err      = 1'b0;
      unique case (state_q)
         LOAD:    in_ready = ~bus.start;
         DONE:    loaded   = 1'b1;
         ERR:     err      = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      word_count_d = word_count_q;
      checksum_d   = checksum_q;
      if (bus.start) begin
         word_count_d = '0;
         checksum_d   = '0;
      end else if (accept) begin
         word_count_d = word_count_q + 1'b1;
         checksum_d   = {checksum_q[DATA_WIDTH-2:0], checksum_q[DATA_WIDTH-1]} ^ bus.in_data;
      end
   end

   // NOTE: the row RAM has no reset; a matrix survives reset and a plain
   // clocked array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[word_count_q[IDX_W-1:0]] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_q <= rd_in_range ? mem[bus.rd_addr[IDX_W-1:0]] : '0;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.loaded     = loaded;
   assign bus.err        = err;
   assign bus.word_count = word_count_q;
   assign bus.checksum   = checksum_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;

endmodule

// File: doc/matrix_ingest_stream.md
MATRIX_INGEST_STREAM -- requirements
Module: matrix_ingest_stream

Parameters
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one matrix row word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, width of row address.
REQ-003 SHALL have parameter DEPTH, default 16, rows per matrix; legal range 1..2**ADDR_WIDTH.

Interface
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  pulse to begin a new matrix load.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  row word.
REQ-010 SHALL have port in_last  input  1  marks final row of a matrix.
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  read row address.
REQ-013 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-014 SHALL have port rd_valid  output  1  rd_data valid strobe.
REQ-015 SHALL have port loaded  output  1  full matrix stored.
REQ-016 SHALL have port err  output  1  framing error latched.
REQ-017 SHALL have port word_count  output  ADDR_WIDTH+1  rows accepted in current load.
REQ-018 SHALL have port checksum  output  DATA_WIDTH  running checksum of accepted rows.

Function
REQ-019 SHALL store rows in internal RAM of DEPTH x DATA_WIDTH.
REQ-020 SHALL implement FSM with states IDLE, LOAD, DONE, ERR.
REQ-021 SHALL, on start=1 in any state, enter LOAD next cycle, clear word_count, checksum, loaded and err.
REQ-022 SHALL drive in_ready=1 only in LOAD and only when start=0; in_ready=0 in IDLE, DONE, ERR.
REQ-023 SHALL accept a beat when in_valid & in_ready; write in_data to RAM[word_count], increment word_count.
REQ-024 SHALL update checksum per accepted beat: checksum <= rotate-left-by-1(checksum) XOR in_data.
REQ-025 SHALL, on accepted beat number DEPTH with in_last=1, enter DONE; loaded=1 from next cycle.
REQ-026 SHALL, on accepted beat number DEPTH with in_last=0, enter ERR (missing last).
REQ-027 SHALL, on accepted beat with in_last=1 before beat DEPTH, enter ERR (short matrix); that beat is still written and counted.
REQ-028 SHALL hold err=1 in ERR until start or reset; ERR leaves word_count and checksum frozen.
REQ-029 SHALL serve reads in every state: rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N, one-cycle latency.
REQ-030 SHALL return rd_data=0 for rd_addr >= DEPTH, with rd_valid=1.
REQ-031 SHALL return old RAM contents on read and write to same address in the same cycle.
REQ-032 SHALL hold rd_data at last value and drive rd_valid=0 when rd_en=0.
REQ-033 SHALL give start priority over a simultaneous in_valid; that beat is not accepted.
REQ-034 SHALL keep the DONE matrix readable until the next start overwrites rows.

Reset
REQ-035 SHALL on reset=1 asynchronously set state IDLE, in_ready=0, loaded=0, err=0, word_count=0, checksum=0, rd_data=0, rd_valid=0.
REQ-036 SHALL NOT clear RAM contents on reset.
REQ-037 SHALL abort any load in progress on reset; post-reset block waits in IDLE for start.

Verification (DEPTH=4, DATA_WIDTH=64)
REQ-038 SHALL cover normal load: start, beats 1,2,3,4 with last on 4th -> loaded=1, word_count=4, checksum=2, reads of addr 0..3 return 1,2,3,4 one cycle after rd_en.
REQ-039 SHALL cover short matrix: start, beats 5,6 with last on 2nd -> err=1, loaded=0, word_count=2, in_ready=0.
REQ-040 SHALL cover missing last: start, 4 beats with in_last=0 -> err=1 after 4th beat; 5th in_valid not accepted.
REQ-041 SHALL cover backpressure/priority: in_valid held high with start asserted mid-stream -> beat in start cycle not counted, word_count=0 next cycle.
REQ-042 SHALL cover reset mid-load: reset after 2 beats -> all outputs zero, IDLE; read of addr 1 returns previously written value.
REQ-043 SHALL cover out-of-range read: rd_addr=5 -> rd_data=0, rd_valid=1 next cycle.
